// File: rtl/axi_to_sram_packer_pkg.sv
// Shared definitions for the AXI-to-SRAM packer and its downstream unpacker:
// entry layout, tag encodings and the packer state enumeration.
package axi_to_sram_packer_pkg;

   localparam int DATA_W      = 256;
   localparam int PAYLOAD_W   = 192;
   localparam int ENTRY_W     = 196;

   localparam int VALID_BIT   = 0;
   localparam int LAST_BIT    = 1;
   localparam int TAG_LSB     = 2;
   localparam int TAG_W       = 2;
   localparam int PAYLOAD_LSB = 4;

   typedef enum logic [1:0] {
      TAG0 = 2'd0,
      TAG1 = 2'd1,
      TAG2 = 2'd2,
      TAG3 = 2'd3
   } tag_e;

   // S0..S2 accept beats; S3, F1 and F2 only drain the held residue.
   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      F1 = 3'd4,
      F2 = 3'd5
   } state_e;

   function automatic logic [ENTRY_W-1:0] make_entry(
      input logic [PAYLOAD_W-1:0] payload,
      input tag_e                 tag,
      input logic                 last
   );
      logic [ENTRY_W-1:0] e;
      e                             = '0;
      e[VALID_BIT]                  = 1'b1;
      e[LAST_BIT]                   = last;
      e[TAG_LSB +: TAG_W]           = tag;
      e[PAYLOAD_LSB +: PAYLOAD_W]   = payload;
      return e;
   endfunction

endpackage

// File: rtl/axi_to_sram_packer.sv
// Packs 256-bit AXI4-Stream beats into 192-bit tagged SRAM FIFO entries:
// three beats become four entries (tags 0..3); short packets drain early.
module axi_to_sram_packer
   import axi_to_sram_packer_pkg::*;
#(
   parameter int TDATA_WIDTH         = 32,
   parameter int CROPPED_TDATA_WIDTH = 24,
   parameter int TUSER_WIDTH         = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   input  logic [TDATA_WIDTH*8-1:0]   s_tdata,
   input  logic [TDATA_WIDTH-1:0]     s_tstrb,
   input  logic [TDATA_WIDTH-1:0]     s_tkeep,
   input  logic                       s_tlast,
   input  logic [TUSER_WIDTH-1:0]     s_tuser,
   output logic [ENTRY_W-1:0]         dout,
   output logic                       dout_valid,
   input  logic                       fifo_almost_full,
   output logic [31:0]                in_word_cnt
);

   localparam int RES_W = CROPPED_TDATA_WIDTH * 8;

   state_e               state_q, state_d;
   logic [RES_W-1:0]     residue_q, residue_d;
   logic [ENTRY_W-1:0]   dout_q, dout_d;
   logic                 dout_valid_q, dout_valid_d;
   logic [31:0]          in_word_cnt_q, in_word_cnt_d;
   logic [DATA_W-1:0]    beat;
   logic                 accept;

   // Strobes, keeps and user bits carry no information for this packer.
   logic unused_inputs;
   assign unused_inputs = ^{s_tstrb, s_tkeep, s_tuser};

   assign beat     = s_tdata;
   assign s_tready = !reset && !fifo_almost_full && (state_q inside {S0, S1, S2});
   assign accept   = s_tvalid && s_tready;

   always_comb begin
      // NOTE: every _d gets a default first so no path can infer a latch.
      state_d       = state_q;
      residue_d     = residue_q;
      dout_d        = dout_q;
      dout_valid_d  = 1'b0;
      in_word_cnt_d = in_word_cnt_q + {31'b0, accept};

      case (state_q)
         S0: if (accept) begin
            dout_d       = make_entry(beat[191:0], TAG0, s_tlast);
            residue_d    = {128'b0, beat[255:192]};
            dout_valid_d = 1'b1;
            state_d      = s_tlast ? F1 : S1;
         end
         S1: if (accept) begin
            dout_d       = make_entry({beat[127:0], residue_q[63:0]}, TAG1, s_tlast);
            residue_d    = {64'b0, beat[255:128]};
            dout_valid_d = 1'b1;
            state_d      = s_tlast ? F2 : S2;
         end
         S2: if (accept) begin
            // A tlast here still needs the full tag3 entry, so both paths go to S3.
            dout_d       = make_entry({beat[63:0], residue_q[127:0]}, TAG2, s_tlast);
            residue_d    = beat[255:64];
            dout_valid_d = 1'b1;
            state_d      = S3;
         end
         S3: if (!fifo_almost_full) begin
            dout_d       = make_entry(residue_q, TAG3, 1'b0);
            dout_valid_d = 1'b1;
            state_d      = S0;
         end
         F1: if (!fifo_almost_full) begin
            dout_d       = make_entry({128'b0, residue_q[63:0]}, TAG1, 1'b0);
            dout_valid_d = 1'b1;
            state_d      = S0;
         end
         F2: if (!fifo_almost_full) begin
            dout_d       = make_entry({64'b0, residue_q[127:0]}, TAG2, 1'b0);
            dout_valid_d = 1'b1;
            state_d      = S0;
         end
         default: state_d = S0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S0;
         residue_q     <= '0;
         dout_q        <= '0;
         dout_valid_q  <= 1'b0;
         in_word_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of the others.
         state_q       <= state_d;
         residue_q     <= residue_d;
         dout_q        <= dout_d;
         dout_valid_q  <= dout_valid_d;
         in_word_cnt_q <= in_word_cnt_d;
      end
   end

   assign dout        = dout_q;
   assign dout_valid  = dout_valid_q;
   assign in_word_cnt = in_word_cnt_q;

endmodule

// File: tb/tb_axi_to_sram_packer.sv
// Self-checking bench: directed packet scenarios plus a random stream fed
// through a bit-stream model of the downstream unpacker.
module tb_axi_to_sram_packer;

   localparam int N_RAND = 400;

   logic           clk = 1'b0;
   logic           reset;
   logic           s_tvalid;
   logic           s_tready;
   logic [255:0]   s_tdata;
   logic [31:0]    s_tstrb;
   logic [31:0]    s_tkeep;
   logic           s_tlast;
   logic [63:0]    s_tuser;
   logic [195:0]   dout;
   logic           dout_valid;
   logic           fifo_almost_full;
   logic [31:0]    in_word_cnt;

   int             n_checks = 0;
   int             n_errors = 0;

   // Expected beats in acceptance order: {tlast, tdata}.
   logic [256:0]   exp_q[$];
   // Unpacker model: four 192-bit slots concatenated into one 768-bit stream.
   logic [767:0]   acc;
   int             last_tag;
   int             acc_cnt;

   axi_to_sram_packer dut (
      .clk              (clk),
      .reset            (reset),
      .s_tvalid         (s_tvalid),
      .s_tready         (s_tready),
      .s_tdata          (s_tdata),
      .s_tstrb          (s_tstrb),
      .s_tkeep          (s_tkeep),
      .s_tlast          (s_tlast),
      .s_tuser          (s_tuser),
      .dout             (dout),
      .dout_valid       (dout_valid),
      .fifo_almost_full (fifo_almost_full),
      .in_word_cnt      (in_word_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_clear();
      exp_q.delete();
      acc      = '0;
      last_tag = -1;
      acc_cnt  = 0;
   endtask

   // Rebuild beats from entries: tag t fills stream bits [t*192 +: 192]; a full
   // group (tag3) yields three beats, a short packet yields tag-count beats.
   task automatic unpack(input logic [195:0] e);
      int           t;
      int           nb;
      logic [767:0] pad;
      logic [256:0] want;
      logic         got_last;
      t = int'(e[3:2]);
      check("entry_valid_bit", 256'(e[0]), 256'd1);
      acc[t*192 +: 192] = e[195:4];
      if (e[1]) last_tag = t;
      if (t == 3 || (last_tag >= 0 && t == last_tag + 1)) begin
         nb = (t == 3) ? 3 : t;
         if (nb < 3) begin
            pad = (acc >> (nb*256)) & ((768'd1 << ((nb+1)*192 - nb*256)) - 768'd1);
            check("drain_zero_pad", pad[255:0], 256'd0);
         end
         for (int b = 0; b < nb; b++) begin
            check("beat_available", 256'(exp_q.size() > 0), 256'd1);
            if (exp_q.size() > 0) begin
               want     = exp_q.pop_front();
               got_last = (last_tag >= 0) && (b == nb - 1);
               check("beat_data", acc[b*256 +: 256], want[255:0]);
               check("beat_last", 256'(got_last), 256'(want[256]));
            end
         end
         acc      = '0;
         last_tag = -1;
      end
   endtask

   always @(negedge clk) begin
      if (!reset && dout_valid) unpack(dout);
   end

   // Called at a falling edge; drives inputs, notes acceptance, advances one cycle.
   task automatic cycle_drive(input bit v, input logic [255:0] d, input logic l,
                              input bit af, output bit took);
      s_tvalid         = v;
      s_tdata          = d;
      s_tlast          = l;
      fifo_almost_full = af;
      s_tuser          = {$urandom(), $urandom()};
      #1;
      took = v && s_tready;
      if (took) begin
         exp_q.push_back({l, d});
         acc_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_beat(input logic [255:0] d, input logic l);
      bit took;
      took = 1'b0;
      for (int n = 0; n < 50 && !took; n++) cycle_drive(1'b1, d, l, 1'b0, took);
      check("beat_accepted", 256'(took), 256'd1);
      s_tvalid = 1'b0;
   endtask

   task automatic idle(input bit af);
      bit took;
      cycle_drive(1'b0, '0, 1'b0, af, took);
   endtask

   task automatic expect_entry(input string name, input logic [1:0] tag, input logic last,
                               input logic [191:0] payload);
      check({name, "_valid"}, 256'(dout_valid), 256'd1);
      check({name, "_entry"}, 256'(dout), 256'({payload, tag, last, 1'b1}));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [255:0] a, b, c, d, e, f, h, j, cur;
      logic [255:0] g[3];
      logic [255:0] tp[9];
      logic         cur_last;
      bit           took, have;
      int           cyc, sent, n_acc, emits;

      reset = 1'b1;
      s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
      s_tstrb = '1; s_tkeep = '1; s_tuser = '0;
      fifo_almost_full = 1'b0;
      model_clear();

      // Reset state
      @(negedge clk);
      check("ready_in_reset", 256'(s_tready), 256'd0);
      @(posedge clk); @(negedge clk);
      check("reset_dout_valid", 256'(dout_valid), 256'd0);
      check("reset_dout", 256'(dout), 256'd0);
      check("reset_cnt", 256'(in_word_cnt), 256'd0);
      reset = 1'b0;
      #1 check("ready_after_reset", 256'(s_tready), 256'd1);
      @(negedge clk);

      // Three-beat packet, no backpressure
      a = rand256(); b = rand256(); c = rand256();
      send_beat(a, 1'b0);
      expect_entry("pkt3_a", 2'd0, 1'b0, a[191:0]);
      send_beat(b, 1'b0);
      expect_entry("pkt3_b", 2'd1, 1'b0, {b[127:0], a[255:192]});
      send_beat(c, 1'b1);
      expect_entry("pkt3_c", 2'd2, 1'b1, {c[63:0], b[255:128]});
      check("pkt3_ready_s3", 256'(s_tready), 256'd0);
      idle(1'b0);
      expect_entry("pkt3_tag3", 2'd3, 1'b0, c[255:64]);
      check("pkt3_cnt", 256'(in_word_cnt), 256'd3);

      // One-beat packet: exactly one drain cycle
      d = rand256();
      send_beat(d, 1'b1);
      expect_entry("pkt1_d", 2'd0, 1'b1, d[191:0]);
      check("pkt1_ready_drain", 256'(s_tready), 256'd0);
      idle(1'b0);
      expect_entry("pkt1_drain", 2'd1, 1'b0, {128'b0, d[255:192]});

      // Two-beat packet
      e = rand256(); f = rand256();
      send_beat(e, 1'b0);
      expect_entry("pkt2_e", 2'd0, 1'b0, e[191:0]);
      send_beat(f, 1'b1);
      expect_entry("pkt2_f", 2'd1, 1'b1, {f[127:0], e[255:192]});
      idle(1'b0);
      expect_entry("pkt2_drain", 2'd2, 1'b0, {64'b0, f[255:128]});
      check("pkt2_ready_s0", 256'(s_tready), 256'd1);
      idle(1'b0);
      check("idle_no_valid", 256'(dout_valid), 256'd0);
      check("idle_dout_hold", 256'(dout), 256'({64'b0, f[255:128], 2'd2, 1'b0, 1'b1}));

      // Backpressure while holding the tag3 residue
      for (int i = 0; i < 3; i++) begin
         g[i] = rand256();
         send_beat(g[i], 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         idle(1'b1);
         check("stall_no_valid", 256'(dout_valid), 256'd0);
         check("stall_ready_low", 256'(s_tready), 256'd0);
      end
      idle(1'b0);
      expect_entry("stall_tag3", 2'd3, 1'b0, g[2][255:64]);

      // Sustained rate: nine back-to-back beats take eleven cycles
      for (int i = 0; i < 9; i++) tp[i] = rand256();
      n_acc = 0; cyc = 0;
      while (n_acc < 9 && cyc < 40) begin
         cycle_drive(1'b1, tp[n_acc], n_acc == 8, 1'b0, took);
         cyc++;
         if (took) n_acc++;
      end
      check("throughput_cycles", 256'(cyc), 256'd11);
      idle(1'b0);
      idle(1'b0);

      // Reset mid-packet discards the residue
      h = rand256();
      send_beat(h, 1'b0);
      expect_entry("rst_h", 2'd0, 1'b0, h[191:0]);
      reset = 1'b1;
      #1 check("rst_ready", 256'(s_tready), 256'd0);
      model_clear();
      @(posedge clk); @(negedge clk);
      check("rst_valid", 256'(dout_valid), 256'd0);
      check("rst_cnt", 256'(in_word_cnt), 256'd0);
      reset = 1'b0;
      emits = 0;
      for (int i = 0; i < 4; i++) begin
         idle(1'b0);
         emits += int'(dout_valid);
      end
      check("rst_no_partial", 256'(emits), 256'd0);
      j = rand256();
      send_beat(j, 1'b0);
      expect_entry("rst_j", 2'd0, 1'b0, j[191:0]);
      check("rst_cnt_restart", 256'(in_word_cnt), 256'd1);

      // Random stream with gaps and backpressure through the unpacker model
      sent = 0; cyc = 0; have = 1'b0; cur = '0; cur_last = 1'b0;
      while (sent < N_RAND && cyc < 20000) begin
         if (!have && $urandom_range(0, 3) != 0) begin
            cur      = rand256();
            cur_last = (sent == N_RAND - 1) || ($urandom_range(0, 5) == 0);
            have     = 1'b1;
         end
         cycle_drive(have, cur, cur_last, $urandom_range(0, 9) < 2, took);
         if (took) begin
            have = 1'b0;
            sent++;
         end
         cyc++;
      end
      check("rand_all_sent", 256'(sent), 256'(N_RAND));
      for (int i = 0; i < 8; i++) idle(1'b0);
      check("rand_cnt", 256'(in_word_cnt), 256'(acc_cnt));
      check("rand_queue_drained", 256'(exp_q.size()), 256'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/axi_to_sram_packer.md
AXI_TO_SRAM_PACKER -- requirements
Module: axi_to_sram_packer

Interface
REQ-001 Parameter TDATA_WIDTH, 32, AXI data width in bytes (256-bit tdata).
REQ-002 Parameter CROPPED_TDATA_WIDTH, 24, SRAM entry payload width in bytes (192-bit payload).
REQ-003 Parameter TUSER_WIDTH, 64, tuser width; accepted and ignored.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s_tvalid  input  1  AXI4-Stream slave valid.
REQ-007 s_tready  output  1  AXI4-Stream slave ready.
REQ-008 s_tdata  input  256  beat data.
REQ-009 s_tstrb / s_tkeep  input  32 each  ignored; every beat is treated as fully populated.
REQ-010 s_tlast  input  1  end of packet.
REQ-011 s_tuser  input  TUSER_WIDTH  ignored.
REQ-012 dout  output  196  SRAM FIFO entry: [195:4] payload, [3:2] tag, [1] last-marker, [0] valid.
REQ-013 dout_valid  output  1  write strobe for dout.
REQ-014 fifo_almost_full  input  1  downstream FIFO almost full, with at least 2 free entries remaining when asserted.
REQ-015 in_word_cnt  output  32  count of accepted AXI beats.

Function
REQ-016 The block SHALL pack three 256-bit beats into four 192-bit entries using tags 0..3, which the downstream unpacker reassembles.
REQ-017 States: S0, S1, S2 (accept beats), S3, F1 and F2 (drain residue, no accept).
REQ-018 s_tready SHALL be 1 only in S0/S1/S2 with fifo_almost_full=0.
REQ-019 A beat is accepted when s_tvalid and s_tready are both 1.
REQ-020 S0 accept: emit tag0 {W[191:0]}; hold residue W[255:192]; go to S1, or to F1 if tlast.
REQ-021 S1 accept: emit tag1 {W[127:0], res64}; hold residue W[255:128]; go to S2, or to F2 if tlast.
REQ-022 S2 accept: emit tag2 {W[63:0], res128}; hold residue W[255:64]; go to S3 in both cases.
REQ-023 S3, when fifo_almost_full=0: emit tag3 {res192}; go to S0.
REQ-024 F1, when fifo_almost_full=0: emit tag1 {128'b0, res64}; go to S0.
REQ-025 F2, when fifo_almost_full=0: emit tag2 {64'b0, res128}; go to S0.
REQ-026 In all braces, the right-most field occupies the lowest payload bits.
REQ-027 dout[1] SHALL be 1 only on the entry emitted for an accepted tlast beat; it is 0 on all other entries, including drain entries.
REQ-028 dout[0] SHALL be 1 on every emitted entry.
REQ-029 dout and dout_valid SHALL be registered: an accept or drain in cycle N produces dout_valid=1 in cycle N+1.
REQ-030 dout_valid SHALL be 0 in every cycle with no emission; dout holds its last value.
REQ-031 A fully packed stream SHALL sustain three beats per four cycles.
REQ-032 A tlast beat in S0 or S1 SHALL cost exactly one extra drain cycle.
REQ-033 Drain states SHALL stall, holding state and residue, while fifo_almost_full=1.
REQ-034 tvalid dropping mid-packet SHALL hold state and residue indefinitely.
REQ-035 in_word_cnt SHALL increment by 1 per accepted beat, wrapping 0xFFFFFFFF to 0.

Reset
REQ-036 Reset SHALL force: state S0, dout_valid 0, dout 0, residue 0, in_word_cnt 0, s_tready 0 during the reset cycle.
REQ-037 Reset mid-packet SHALL discard the residue without emitting a partial entry; the first beat after reset is packed as tag0.

Structure
REQ-038 A shared package SHALL hold: entry width 196, tag encodings, field bit positions, and the state enumeration.
REQ-039 The downstream unpacker SHALL use the same package.
REQ-040 The block SHALL be a single module with no sub-module.

Verification
REQ-041 3-beat packet A,B,C (C tlast), no backpressure: 4 consecutive entries with tags 0,1,2,3; [1] set only on the C entry; s_tready low in the 4th cycle; in_word_cnt=3.
REQ-042 1-beat packet D (tlast): tag0 {D[191:0]} with [1]=1, then tag1 {128'b0, D[255:192]}; next beat packed as tag0.
REQ-043 2-beat packet E,F (F tlast): tag0, tag1 {F[127:0], E[255:192]} with [1]=1, tag2 {64'b0, F[255:128]}; then S0.
REQ-044 fifo_almost_full asserted in S3 for 5 cycles: no dout_valid and s_tready=0 for those cycles; the tag3 entry emits one cycle after deassertion.
REQ-045 Reset after beat 1 of a packet: dout_valid=0 from the reset cycle onward; the next packet starts at tag0 and in_word_cnt counts from 0.
REQ-046 Scoreboard: a random-length stream through a model of the downstream unpacker SHALL reproduce all beats and tlast bit-exact.
